// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// The producer/consumer side uses master; the divider uses slave.
interface seq_restoring_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
// IDLE accepts operands, CALC runs DW steps, DONE holds the result until taken.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dsh;
  logic [VW-1:0] dvs;
  logic [DW-1:0] quo;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          dbz;

  logic          accept;
  logic          last;
  logic [VW:0]   r_sh;
  logic          ge;
  logic [VW-1:0] r_sub;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == CW'(DW - 1));

  // Stored remainder is always < divisor, so it fits in VW bits; the shifted
  // value needs one extra bit for the compare.
  assign r_sh   = {rem, dsh[DW-1]};
  assign ge     = (r_sh >= {1'b0, dvs});
  // When ge holds the true difference is < divisor, so the low VW bits of a
  // modular subtract are exact.
  assign r_sub  = r_sh[VW-1:0] - dvs;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dsh   <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            dsh <= bus.dividend;
            dvs <= bus.divisor;
            cnt <= '0;
            if (bus.divisor == '0) begin
              quo <= '1;
              rem <= bus.dividend[VW-1:0];
              dbz <= 1'b1;
            end else begin
              quo <= '0;
              rem <= '0;
              dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          dsh <= {dsh[DW-2:0], 1'b0};
          rem <= ge ? r_sub : r_sh[VW-1:0];
          quo <= {quo[DW-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for seq_restoring_divider (8/4 configuration).
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_restoring_divider_if #(.DW(8), .VW(4)) bus ();

  seq_restoring_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Present operands, wait for acceptance, then count edges to out_valid.
  // Called and returns at a negedge; lat = -1 on timeout.
  task automatic do_op(input logic [7:0] n, input logic [3:0] d, input logic rdy,
                       output int lat, output int wt);
    bus.dividend = n;
    bus.divisor  = d;
    bus.in_valid = 1'b1;
    bus.out_ready = rdy;
    wt = 0;
    while (!bus.in_ready && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = ~n;
    bus.divisor  = d ^ 4'h5;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.quotient !== 8'd0) begin failures++; $display("FAIL reset_quotient got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin failures++; $display("FAIL reset_remainder got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, wt;
    do_op(8'd143, 4'd11, 1'b1, lat, wt);
    checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (bus.quotient !== 8'd13) begin failures++; $display("FAIL basic_quotient got=%0d exp=13", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin failures++; $display("FAIL basic_remainder got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", bus.div_by_zero); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_one_cycle_done out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] vn [5] = '{8'd255, 8'd7, 8'd0,  8'd100, 8'd8};
    logic [3:0] vd [5] = '{4'd1,   4'd9, 4'd15, 4'd7,   4'd3};
    logic [7:0] vq [5] = '{8'd255, 8'd0, 8'd0,  8'd14,  8'd2};
    logic [3:0] vr [5] = '{4'd0,   4'd7, 4'd0,  4'd2,   4'd2};
    int lat, wt;
    for (int i = 0; i < 5; i++) begin
      do_op(vn[i], vd[i], 1'b0, lat, wt);
      checks++; if (bus.quotient !== vq[i] || bus.remainder !== vr[i] || bus.div_by_zero !== 1'b0 || lat !== 9) begin
        failures++;
        $display("FAIL vec_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d exp q=%0d r=%0d dbz=0 lat=9",
                 vn[i], vd[i], bus.quotient, bus.remainder, bus.div_by_zero, lat, vq[i], vr[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_by_zero();
    int lat, wt;
    do_op(8'd200, 4'd0, 1'b0, lat, wt);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (bus.quotient !== 8'd255) begin failures++; $display("FAIL dbz_quotient got=%0d exp=255", bus.quotient); end
    checks++; if (bus.remainder !== 4'd8) begin failures++; $display("FAIL dbz_remainder got=%0d exp=8", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, wt;
    do_op(8'd143, 4'd11, 1'b0, lat, wt);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      bus.dividend = 8'd50 + 8'(c);
      bus.divisor  = 4'd3;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'd13 || bus.remainder !== 4'd0) begin
        failures++;
        $display("FAIL hold_%0d got ov=%b ir=%b q=%0d r=%0d exp ov=1 ir=0 q=13 r=0",
                 c, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL hold_not_queued got ir=%b busy=%b exp 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int lat, wt;
    logic saw;
    bus.dividend = 8'd143; bus.divisor = 4'd11; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL calc_busy got busy=%b ir=%b exp 1/0", bus.busy, bus.in_ready);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
                  bus.quotient !== 8'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got ir=%b busy=%b ov=%b q=%0d r=%0d dbz=%b exp 1/0/0/0/0/0",
               bus.in_ready, bus.busy, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL midreset_no_output got out_valid seen=%b exp=0", saw); end
    do_op(8'd100, 4'd7, 1'b0, lat, wt);
    checks++; if (bus.quotient !== 8'd14 || bus.remainder !== 4'd2 || lat !== 9) begin
      failures++; $display("FAIL midreset_100_7 got q=%0d r=%0d lat=%0d exp q=14 r=2 lat=9", bus.quotient, bus.remainder, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, wt;
    do_op(8'd143, 4'd11, 1'b1, lat, wt);
    do_op(8'd100, 4'd7, 1'b1, lat, wt);
    checks++; if (wt !== 1) begin failures++; $display("FAIL b2b_accept_gap got=%0d exp=1", wt); end
    checks++; if (bus.quotient !== 8'd14 || bus.remainder !== 4'd2 || lat !== 9) begin
      failures++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d exp q=14 r=2 lat=9", bus.quotient, bus.remainder, lat);
    end
    consume();
  endtask

  task automatic test_sweep();
    int lat, wt, q, r, n, d, bad;
    bad = 0;
    for (int ni = 0; ni < 256; ni++) begin
      for (int di = 0; di < 16; di++) begin
        do_op(8'(ni), 4'(di), 1'($urandom_range(0, 1)), lat, wt);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        q = int'(bus.quotient); r = int'(bus.remainder); n = ni; d = di;
        checks++;
        if (d == 0) begin
          if (q != 255 || r != (n % 16) || bus.div_by_zero !== 1'b1 || lat != 1) bad = 1;
        end else begin
          if (q * d + r != n || r >= d || bus.div_by_zero !== 1'b0 || lat != 9) bad = 1;
        end
        if (bad != 0) begin
          failures++;
          $display("FAIL sweep_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d", n, d, q, r, bus.div_by_zero, lat);
          bad = 0;
        end
        consume();
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_div_by_zero();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
